pencoder_inv_mask: RTL and testbench

- Sequential inverse of the 8-to-3 leading-one priority encoder.
- Accepts a valid/ready stream of 3-bit positions, one beat per essential bit, and rebuilds the 8-bit bitmask of each word. Positions use the encoder's numbering: pos 0 is the MSB (bit 7) and pos 7 is the LSB (bit 0).
- Sits on the decompression side of the bit-sparse datapath, between the position FIFO and the bit-serial PE lane. It emits one completed mask plus its popcount per word.

---
 rtl/pencoder_inv_mask.sv | 131 +++++++++++++
 tb/tb_pencoder_inv_mask.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pencoder_inv_mask.sv
// Purpose : rebuilds the MASK_W-bit bitmask of each word from a stream of MSB-relative bit positions.
// Latency : 1 cycle from the accepted closing beat to out_valid.
// Backpressure: in_ready = !out_valid | out_ready. A stalled output blocks all input beats.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   in_valid/in_ready              input beat handshake
//   in_pos                         bit position, 0 = bit MASK_W-1
//   in_last                        beat closes the word
//   in_zero                        word closes with no new bit (in_pos ignored)
//   out_valid/out_ready            completed-mask handshake
//   out_mask, out_count            reconstructed mask and its popcount
//   busy                           a word is open
//   order_err (optional)           sticky flag: positions within a word not strictly increasing
//
// Optional feature macro: PENCODER_INV_ORDER_CHECK_EN (adds order_err and its tracking state).

module pencoder_inv_mask #(
    parameter int MASK_W = 8,
    parameter int POS_W  = $clog2(MASK_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [POS_W-1:0]  in_pos,
    input  logic              in_last,
    input  logic              in_zero,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MASK_W-1:0] out_mask,
    output logic [POS_W:0]    out_count,
    output logic              busy
`ifdef PENCODER_INV_ORDER_CHECK_EN
    ,
    output logic              order_err
`endif
);

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t              state;
    logic [MASK_W-1:0]   acc_mask;

    logic                accept;
    logic                closing;
    logic [POS_W-1:0]    bit_idx;
    logic [MASK_W-1:0]   dec_bit;
    logic [MASK_W-1:0]   merged;
    logic [MASK_W-1:0]   close_mask;

    function automatic logic [POS_W:0] popcount(input logic [MASK_W-1:0] m);
        logic [POS_W:0] c;
        c = '0;
        for (int i = 0; i < MASK_W; i++) begin
            c = c + {{POS_W{1'b0}}, m[i]};
        end
        return c;
    endfunction

    // Ready depends only on the output register, so there is no in_* -> in_ready path.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign closing  = in_zero || in_last;

    assign bit_idx  = POS_W'(MASK_W - 1) - in_pos;
    assign dec_bit  = MASK_W'(1) << bit_idx;

    // acc_mask is held at zero in IDLE, so one OR serves both the first beat and later beats.
    assign merged     = acc_mask | dec_bit;
    // A zero beat contributes no bit; it just closes whatever has been gathered so far.
    assign close_mask = in_zero ? acc_mask : merged;

    assign busy = (state == ACCUM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc_mask  <= '0;
            out_mask  <= '0;
            out_count <= '0;
            out_valid <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                case (state)
                    IDLE, ACCUM: begin
                        if (closing) begin
                            // Overrides the drain above: back-to-back words keep out_valid high.
                            out_valid <= 1'b1;
                            out_mask  <= close_mask;
                            out_count <= popcount(close_mask);
                            acc_mask  <= '0;
                            state     <= IDLE;
                        end else begin
                            acc_mask  <= merged;
                            state     <= ACCUM;
                        end
                    end
                    default: begin
                        acc_mask <= '0;
                        state    <= IDLE;
                    end
                endcase
            end
        end
    end

`ifdef PENCODER_INV_ORDER_CHECK_EN
    logic [POS_W-1:0] last_pos;

    // Encoder emits positions MSB-first, so each beat after the first must be strictly larger.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_pos  <= '0;
            order_err <= 1'b0;
        end else if (accept && !in_zero) begin
            if ((state == ACCUM) && (in_pos <= last_pos)) begin
                order_err <= 1'b1;
            end
            last_pos <= in_pos;
        end
    end
`endif

endmodule

// File: tb/tb_pencoder_inv_mask.sv
module tb_pencoder_inv_mask;

    localparam int MASK_W = 8;
    localparam int POS_W  = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [POS_W-1:0]  in_pos = '0;
    logic              in_last = 1'b0;
    logic              in_zero = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [MASK_W-1:0] out_mask;
    logic [POS_W:0]    out_count;
    logic              busy;
`ifdef PENCODER_INV_ORDER_CHECK_EN
    logic              order_err;
`endif

    pencoder_inv_mask #(.MASK_W(MASK_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pos    (in_pos),
        .in_last   (in_last),
        .in_zero   (in_zero),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mask  (out_mask),
        .out_count (out_count),
        .busy      (busy)
`ifdef PENCODER_INV_ORDER_CHECK_EN
        ,
        .order_err (order_err)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0] pos;
        bit         last;
        bit         zero;
        bit         e_valid;
        logic [7:0] e_mask;
        int         e_count;
        bit         e_busy;
    } vec_t;

    vec_t vt[15];

    function automatic vec_t mk(input int p, input bit l, input bit z, input bit v,
                                input int m, input int c, input bit b);
        vec_t r;
        r.pos = 3'(p); r.last = l; r.zero = z; r.e_valid = v;
        r.e_mask = 8'(m); r.e_count = c; r.e_busy = b;
        return r;
    endfunction

    // Reference model: a word is the set of distinct positions seen; mask is the sum of their weights.
    int word_pos[$];
    int exp_mask_q[$];
    int exp_cnt_q[$];

    task automatic model_close(input bit add_pos, input int p);
        bit seen[MASK_W];
        int m, c;
        for (int k = 0; k < MASK_W; k++) seen[k] = 0;
        if (add_pos) word_pos.push_back(p);
        foreach (word_pos[k]) seen[word_pos[k]] = 1;
        m = 0; c = 0;
        for (int k = 0; k < MASK_W; k++) begin
            if (seen[k]) begin
                m = m + (2 ** (MASK_W - 1 - k));
                c = c + 1;
            end
        end
        exp_mask_q.push_back(m);
        exp_cnt_q.push_back(c);
        word_pos.delete();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0]  = mk(0, 1, 0, 1, 'h80, 1, 0);
        vt[1]  = mk(1, 0, 0, 0, 0, 0, 1);
        vt[2]  = mk(4, 0, 0, 0, 0, 0, 1);
        vt[3]  = mk(7, 1, 0, 1, 'h49, 3, 0);
        vt[4]  = mk(0, 0, 1, 1, 'h00, 0, 0);
        vt[5]  = mk(7, 1, 0, 1, 'h01, 1, 0);
        vt[6]  = mk(2, 0, 0, 0, 0, 0, 1);
        vt[7]  = mk(2, 0, 0, 0, 0, 0, 1);
        vt[8]  = mk(5, 1, 0, 1, 'h24, 2, 0);
        vt[9]  = mk(3, 0, 0, 0, 0, 0, 1);
        vt[10] = mk(6, 0, 1, 1, 'h10, 1, 0);
        vt[11] = mk(0, 0, 0, 0, 0, 0, 1);
        vt[12] = mk(7, 1, 1, 1, 'h80, 1, 0);
        vt[13] = mk(5, 1, 1, 1, 'h00, 0, 0);
        vt[14] = mk(3, 1, 0, 1, 'h10, 1, 0);

        // Reset state
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_mask", out_mask, 0);
        chk("rst_out_count", out_count, 0);
        chk("rst_in_ready", in_ready, 1);
`ifdef PENCODER_INV_ORDER_CHECK_EN
        chk("rst_order_err", order_err, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven back-to-back beats with out_ready held high
        out_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            in_valid = 1'b1;
            in_pos   = vt[i].pos;
            in_last  = vt[i].last;
            in_zero  = vt[i].zero;
            @(posedge clk); #1;
            chk($sformatf("vec%0d_valid", i), out_valid, vt[i].e_valid);
            chk($sformatf("vec%0d_busy", i), busy, vt[i].e_busy);
            if (vt[i].e_valid) begin
                chk($sformatf("vec%0d_mask", i), out_mask, vt[i].e_mask);
                chk($sformatf("vec%0d_count", i), out_count, vt[i].e_count);
            end
`ifdef PENCODER_INV_ORDER_CHECK_EN
            if (i == 6) chk("order_err_before_dup", order_err, 0);
            if (i >= 7) chk($sformatf("vec%0d_order_err", i), order_err, 1);
`endif
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("drain_valid", out_valid, 0);

        // Stall: output held, input blocked, then released with a closing beat present
        out_ready = 1'b0;
        in_valid = 1'b1; in_pos = 3'd0; in_last = 1'b1; in_zero = 1'b0;
        @(posedge clk); #1;
        chk("stall_first_valid", out_valid, 1);
        chk("stall_first_mask", out_mask, 'h80);
        in_pos = 3'd3;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk($sformatf("stall%0d_in_ready", i), in_ready, 0);
            chk($sformatf("stall%0d_valid", i), out_valid, 1);
            chk($sformatf("stall%0d_mask", i), out_mask, 'h80);
            chk($sformatf("stall%0d_busy", i), busy, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_valid", out_valid, 1);
        chk("release_mask", out_mask, 'h10);
        chk("release_count", out_count, 1);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("release_drain", out_valid, 0);

        // Reset in the middle of an open word
        in_valid = 1'b1; in_pos = 3'd0; in_last = 1'b0; in_zero = 1'b0;
        @(posedge clk); #1;
        in_pos = 3'd3;
        @(posedge clk); #1;
        chk("midword_busy", busy, 1);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_mask", out_mask, 0);
        chk("async_rst_count", out_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1; in_pos = 3'd6; in_last = 1'b1; in_zero = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_mask", out_mask, 'h02);
        chk("post_rst_count", out_count, 1);
        chk("post_rst_busy", busy, 0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_drain", out_valid, 0);

        // Randomized traffic against the reference model
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit acc_exp;
            bit pend;
            in_valid  = ($urandom_range(0, 3) != 0);
            in_pos    = 3'($urandom_range(0, 7));
            in_last   = ($urandom_range(0, 2) == 0);
            in_zero   = ($urandom_range(0, 9) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            pend = (exp_mask_q.size() != 0);
            chk("rnd_out_valid", out_valid, pend);
            chk("rnd_in_ready", in_ready, (!pend) || out_ready);
            chk("rnd_busy", busy, word_pos.size() != 0);
            acc_exp = in_valid && (!pend || out_ready);
            if (pend && out_ready) begin
                chk("rnd_mask", out_mask, exp_mask_q.pop_front());
                chk("rnd_count", out_count, exp_cnt_q.pop_front());
            end
            if (acc_exp) begin
                if (in_zero) model_close(1'b0, 0);
                else if (in_last) model_close(1'b1, int'(in_pos));
                else word_pos.push_back(int'(in_pos));
            end
            @(posedge clk); #1;
        end

        // Drain whatever the model still expects, with a bounded wait
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int w = 0; w < 10 && exp_mask_q.size() != 0; w++) begin
            @(negedge clk);
            if (out_valid) begin
                chk("final_mask", out_mask, exp_mask_q.pop_front());
                chk("final_count", out_count, exp_cnt_q.pop_front());
            end
            @(posedge clk); #1;
        end
        chk("final_queue_empty", exp_mask_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
